gray_counter_param: RTL and testbench

Parametrised Gray-code counter, the generalised successor of the fixed 4-bit incrementing Gray counter. It adds configurable width, enable, up/down direction, synchronous clear, parallel load in Gray code, and wrap or saturate mode. It also provides wrap and limit status outputs. It serves as a pointer or sequence generator wherever a single-bit-change count must cross a clock domain or drive low-glitch logic.

---
 rtl/gray_counter_param.sv | 85 ++++++++
 tb/tb_gray_counter_param.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_counter_param.sv
// Parametrised Gray-code counter: binary state register with a registered Gray
// image, up/down counting, clear, Gray-coded load, and wrap or saturate limits.
module gray_counter_param #(
  parameter int unsigned WIDTH = 4,
  parameter bit          WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] gray_count,
  output logic [WIDTH-1:0] bin_count,
  output logic             wrapped,
  output logic             at_limit
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] gray_q;
  logic             wrap_q;
  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] nxt_bin;
  logic             nxt_wrap;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    load_bin = load_gray;
    for (int unsigned i = 1; i < WIDTH; i++) begin
      load_bin[WIDTH-1-i] = load_bin[WIDTH-i] ^ load_gray[WIDTH-1-i];
    end
  end

  always_comb begin
    nxt_bin  = bin_q;
    nxt_wrap = 1'b0;
    if (clr) begin
      nxt_bin = '0;
    end else if (load) begin
      nxt_bin = load_bin;
    end else if (en) begin
      if (up) begin
        if (bin_q == ALL_ONES) begin
          if (WRAP) begin
            nxt_bin  = '0;
            nxt_wrap = 1'b1;
          end
        end else begin
          nxt_bin = bin_q + 1'b1;
        end
      end else begin
        if (bin_q == '0) begin
          if (WRAP) begin
            nxt_bin  = ALL_ONES;
            nxt_wrap = 1'b1;
          end
        end else begin
          nxt_bin = bin_q - 1'b1;
        end
      end
    end
  end

  // Gray image is registered alongside the binary value so both always agree.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= nxt_bin;
      gray_q <= nxt_bin ^ (nxt_bin >> 1);
      wrap_q <= nxt_wrap;
    end
  end

  assign bin_count  = bin_q;
  assign gray_count = gray_q;
  assign wrapped    = wrap_q;
  assign at_limit   = up ? (bin_q == ALL_ONES) : (bin_q == '0);

endmodule

// File: tb/tb_gray_counter_param.sv
// Self-checking bench for gray_counter_param: four instances (4-bit wrap, 4-bit
// saturate, 8-bit wrap, 2-bit wrap) checked against an arithmetic count model.
module tb_gray_counter_param;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clr = 1'b0, load = 1'b0, en = 1'b0, up = 1'b1;
  logic [31:0] lg_all = '0;

  logic [3:0] g4, b4, gs, bs;
  logic [7:0] g8, b8;
  logic [1:0] g2, b2;
  logic       w4, a4, ws, as_, w8, a8, w2, a2;

  logic [31:0] gq[4], bq[4];
  logic        wq[4], aq[4];

  int errors = 0;
  int checks = 0;

  int unsigned W[4]  = '{4, 4, 8, 2};
  bit          WR[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  int unsigned mv[4] = '{0, 0, 0, 0};
  bit          mw[4] = '{1'b0, 1'b0, 1'b0, 1'b0};

  always #5 clk = ~clk;

  gray_counter_param #(.WIDTH(4), .WRAP(1'b1)) u_w4 (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .load_gray(lg_all[3:0]),
    .en(en), .up(up), .gray_count(g4), .bin_count(b4), .wrapped(w4), .at_limit(a4));
  gray_counter_param #(.WIDTH(4), .WRAP(1'b0)) u_sat (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .load_gray(lg_all[3:0]),
    .en(en), .up(up), .gray_count(gs), .bin_count(bs), .wrapped(ws), .at_limit(as_));
  gray_counter_param #(.WIDTH(8), .WRAP(1'b1)) u_w8 (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .load_gray(lg_all[7:0]),
    .en(en), .up(up), .gray_count(g8), .bin_count(b8), .wrapped(w8), .at_limit(a8));
  gray_counter_param #(.WIDTH(2), .WRAP(1'b1)) u_w2 (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .load_gray(lg_all[1:0]),
    .en(en), .up(up), .gray_count(g2), .bin_count(b2), .wrapped(w2), .at_limit(a2));

  always_comb begin
    gq[0] = {28'd0, g4}; bq[0] = {28'd0, b4}; wq[0] = w4; aq[0] = a4;
    gq[1] = {28'd0, gs}; bq[1] = {28'd0, bs}; wq[1] = ws; aq[1] = as_;
    gq[2] = {24'd0, g8}; bq[2] = {24'd0, b8}; wq[2] = w8; aq[2] = a8;
    gq[3] = {30'd0, g2}; bq[3] = {30'd0, b2}; wq[3] = w2; aq[3] = a2;
  end

  function automatic int unsigned maxv(int i);
    return (32'd1 << W[i]) - 1;
  endfunction

  function automatic int unsigned to_gray(int unsigned v);
    return v ^ (v >> 1);
  endfunction

  function automatic int unsigned g2b(int unsigned g);
    int unsigned b = g;
    for (int s = 1; s < 32; s++) b = b ^ (g >> s);
    return b;
  endfunction

  function automatic bit exp_limit(int i);
    return up ? (mv[i] == maxv(i)) : (mv[i] == 0);
  endfunction

  function automatic void model_next(input int i, output int unsigned v, output bit w);
    v = mv[i];
    w = 1'b0;
    if (clr) v = 0;
    else if (load) v = g2b(lg_all & maxv(i));
    else if (en) begin
      if (up) begin
        if (mv[i] == maxv(i)) begin
          if (WR[i]) begin v = 0; w = 1'b1; end
        end else v = mv[i] + 1;
      end else begin
        if (mv[i] == 0) begin
          if (WR[i]) begin v = maxv(i); w = 1'b1; end
        end else v = mv[i] - 1;
      end
    end
  endfunction

  task automatic tick();
    int unsigned nv[4];
    bit          nw[4];
    for (int i = 0; i < 4; i++) begin
      if (!reset) begin nv[i] = 0; nw[i] = 1'b0; end
      else model_next(i, nv[i], nw[i]);
    end
    @(posedge clk);
    #1;
    mv = nv;
    mw = nw;
  endtask

  task automatic test_reset();
    reset = 1'b0; en = 1'b1; up = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (gq[i] !== 0 || bq[i] !== 0 || wq[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state[%0d]: gray=%0h bin=%0h wrapped=%0b, expected all 0", i, gq[i], bq[i], wq[i]);
      end
    end
    up = 1'b0; #1;
    checks++;
    if (a4 !== 1'b1) begin errors++; $display("FAIL reset_limit_down: at_limit=%0b expected 1", a4); end
    up = 1'b1; #1;
    checks++;
    if (a4 !== 1'b0) begin errors++; $display("FAIL reset_limit_up: at_limit=%0b expected 0", a4); end
  endtask

  task automatic test_up_count();
    logic [3:0] seq [17] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                             4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
    reset = 1'b1; en = 1'b1; up = 1'b1;
    checks++;
    if (g4 !== seq[0]) begin errors++; $display("FAIL up_start: gray=%0h expected %0h", g4, seq[0]); end
    for (int k = 1; k <= 16; k++) begin
      checks++;
      if (a4 !== (k == 16)) begin
        errors++; $display("FAIL up_at_limit[%0d]: at_limit=%0b expected %0b", k, a4, (k == 16));
      end
      tick();
      checks++;
      if (g4 !== seq[k] || wq[0] !== (k == 16)) begin
        errors++;
        $display("FAIL up_seq[%0d]: gray=%0h wrapped=%0b expected gray=%0h wrapped=%0b", k, g4, w4, seq[k], (k == 16));
      end
    end
  endtask

  task automatic test_down_wrap();
    up = 1'b0; en = 1'b1;
    #1;
    checks++;
    if (a4 !== 1'b1) begin errors++; $display("FAIL down_limit: at_limit=%0b expected 1", a4); end
    tick();
    checks++;
    if (b4 !== 4'hF || g4 !== 4'h8 || w4 !== 1'b1) begin
      errors++; $display("FAIL down_wrap1: bin=%0h gray=%0h wrapped=%0b expected F 8 1", b4, g4, w4);
    end
    tick();
    checks++;
    if (b4 !== 4'hE || g4 !== 4'h9 || w4 !== 1'b0) begin
      errors++; $display("FAIL down_wrap2: bin=%0h gray=%0h wrapped=%0b expected E 9 0", b4, g4, w4);
    end
  endtask

  task automatic test_saturate();
    load = 1'b1; lg_all = 32'h8; en = 1'b1; up = 1'b1;
    tick();
    load = 1'b0;
    checks++;
    if (bs !== 4'hF) begin errors++; $display("FAIL sat_load: bin=%0h expected F", bs); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (bs !== 4'hF || ws !== 1'b0 || as_ !== 1'b1) begin
        errors++; $display("FAIL sat_hold[%0d]: bin=%0h wrapped=%0b at_limit=%0b expected F 0 1", k, bs, ws, as_);
      end
    end
    up = 1'b0;
    tick();
    checks++;
    if (bs !== 4'hE) begin errors++; $display("FAIL sat_down: bin=%0h expected E", bs); end
  endtask

  task automatic test_load_priority();
    load = 1'b1; lg_all = 32'h6; en = 1'b1; up = 1'b1;
    tick();
    checks++;
    if (b4 !== 4'h4 || g4 !== 4'h6) begin
      errors++; $display("FAIL load_en: bin=%0h gray=%0h expected 4 6", b4, g4);
    end
    clr = 1'b1;
    tick();
    checks++;
    if (b4 !== 4'h0 || g4 !== 4'h0) begin
      errors++; $display("FAIL clr_priority: bin=%0h gray=%0h expected 0 0", b4, g4);
    end
    clr = 1'b0;
    tick();
    load = 1'b0; en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (b4 !== 4'h4 || g4 !== 4'h6 || w4 !== 1'b0) begin
        errors++; $display("FAIL hold[%0d]: bin=%0h gray=%0h expected 4 6", k, b4, g4);
      end
    end
  endtask

  task automatic test_async_reset();
    clr = 1'b1;
    tick();
    clr = 1'b0; en = 1'b1; up = 1'b1;
    repeat (9) tick();
    checks++;
    if (b4 !== 4'h9) begin errors++; $display("FAIL pre_reset_count: bin=%0h expected 9", b4); end
    #2;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin mv[i] = 0; mw[i] = 1'b0; end
    checks++;
    if (g4 !== 4'h0 || b4 !== 4'h0 || w4 !== 1'b0 || b8 !== 8'h0) begin
      errors++; $display("FAIL async_reset: gray=%0h bin=%0h wrapped=%0b expected 0 0 0", g4, b4, w4);
    end
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (g4 !== 4'h1 || g8 !== 8'h1) begin
      errors++; $display("FAIL restart: gray=%0h expected 1", g4);
    end
  endtask

  task automatic test_random();
    int unsigned prev[4];
    bit          stepped;
    for (int n = 0; n < 2000; n++) begin
      en     = ($urandom_range(0, 3) != 0);
      up     = $urandom_range(0, 1);
      clr    = ($urandom_range(0, 63) == 0);
      load   = ($urandom_range(0, 31) == 0);
      lg_all = $urandom;
      stepped = !clr && !load;
      #1;
      for (int i = 0; i < 4; i++) begin
        prev[i] = gq[i];
        checks++;
        if (aq[i] !== exp_limit(i)) begin
          errors++; $display("FAIL rnd_limit[%0d] n=%0d: at_limit=%0b expected %0b", i, n, aq[i], exp_limit(i));
        end
      end
      tick();
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (bq[i] !== mv[i] || gq[i] !== to_gray(mv[i]) || wq[i] !== mw[i]) begin
          errors++;
          $display("FAIL rnd_state[%0d] n=%0d: bin=%0h gray=%0h wrapped=%0b expected %0h %0h %0b",
                   i, n, bq[i], gq[i], wq[i], mv[i], to_gray(mv[i]), mw[i]);
        end
        checks++;
        if (bq[i] !== g2b(gq[i])) begin
          errors++; $display("FAIL rnd_conv[%0d] n=%0d: bin=%0h expected %0h", i, n, bq[i], g2b(gq[i]));
        end
        if (stepped && gq[i] != prev[i]) begin
          checks++;
          if ($countones(gq[i] ^ prev[i]) != 1) begin
            errors++; $display("FAIL rnd_onebit[%0d] n=%0d: gray %0h -> %0h, expected 1 bit change", i, n, prev[i], gq[i]);
          end
        end
      end
    end
    clr = 1'b0; load = 1'b0; en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_down_wrap();
    test_saturate();
    test_load_priority();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
